// File: rtl/nios2e_key_pio.sv
// Avalon-MM key/switch PIO: synchronised input pins, per-bit edge capture
// with write-1-to-clear, interrupt mask and a level interrupt.
module nios2e_key_pio #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned EDGE_TYPE = 1,
    parameter int unsigned IRQ_EN    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned ARM_W    = 2;
    localparam int unsigned DATA_W   = 32;
    localparam logic [1:0]  ADDR_DATA = 2'd0;
    localparam logic [1:0]  ADDR_MASK = 2'd2;
    localparam logic [1:0]  ADDR_ECAP = 2'd3;
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(3);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] s3_q, s3_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [ARM_W-1:0] arm_q, arm_d;

    logic             wr_en_c;
    logic             armed_c;
    logic [WIDTH-1:0] wdata_c;
    logic [WIDTH-1:0] edge_raw_c;
    logic [WIDTH-1:0] edge_det_c;
    logic [WIDTH-1:0] clr_c;

    // Upper write-data bits have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en_c = chipselect & ~write_n;
    assign wdata_c = writedata[WIDTH-1:0];
    assign armed_c = (arm_q == ARM_DONE);

    // Per-bit edge detect on the synchronised history, selected by mode.
    always_comb begin
        edge_raw_c = '0;
        case (EDGE_TYPE)
            0:       edge_raw_c = s2_q & ~s3_q;
            1:       edge_raw_c = ~s2_q & s3_q;
            default: edge_raw_c = s2_q ^ s3_q;
        endcase
    end

    // Detection masked until the arm counter saturates after reset.
    assign edge_det_c = armed_c ? edge_raw_c : '0;

    // Next-state for synchroniser, arm counter, mask and capture registers.
    always_comb begin
        s1_d      = in_port;
        s2_d      = s1_q;
        s3_d      = s2_q;
        arm_d     = arm_q;
        mask_d    = mask_q;
        clr_c     = '0;
        if (!armed_c) begin
            arm_d = arm_q + ARM_W'(1);
        end
        if (wr_en_c && (address == ADDR_MASK)) begin
            mask_d = wdata_c;
        end
        if (wr_en_c && (address == ADDR_ECAP)) begin
            clr_c = wdata_c;
        end
        // A new edge overrides a clear landing on the same bit.
        edgecap_d = (edgecap_q & ~clr_c) | edge_det_c;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            arm_q     <= '0;
            mask_q    <= '0;
            edgecap_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            arm_q     <= arm_d;
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Zero-wait read mux, independent of chipselect.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA: readdata = DATA_W'(s2_q);
            ADDR_MASK: readdata = DATA_W'(mask_q);
            ADDR_ECAP: readdata = DATA_W'(edgecap_q);
            default:   readdata = '0;
        endcase
    end

    // Level interrupt from masked captures, or tied low when disabled.
    generate
        if (IRQ_EN != 0) begin : g_irq
            assign irq = |(edgecap_q & mask_q);
        end else begin : g_no_irq
            assign irq = 1'b0;
        end
    endgenerate

endmodule
